// File: rtl/regs_wb_ctrl_pkg.sv
// ============================================================================
// Module      : regs_wb_ctrl_pkg
// Description : Shared widths and writeback source encoding for regs_wb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regs_wb_ctrl_pkg;

    localparam int TAM        = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NREG       = 16;
    localparam int STARVE_W   = 3;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } src_e;

endpackage

`default_nettype wire

// File: rtl/regs_scoreboard.sv
// ============================================================================
// Module      : regs_scoreboard
// Description : Outstanding-load busy vector with issue-side hazard compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_scoreboard
    import regs_wb_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_valid_i,
    input  logic                  set_req_i,
    input  logic [REG_ADDR_W-1:0] dst_i,
    input  logic [REG_ADDR_W-1:0] src1_i,
    input  logic [REG_ADDR_W-1:0] src2_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    output logic [NREG-1:0]       busy_o,
    output logic                  hazard_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            w_set_en;

    assign hazard_o = chk_valid_i & (busy_q[src1_i] | busy_q[src2_i] | busy_q[dst_i]);
    assign w_set_en = set_req_i & ~hazard_o & (dst_i != '0);
    assign busy_o   = busy_q;

    // Set is applied after clear so a same-register collision leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (w_set_en) begin
            busy_d[dst_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regs_wb_ctrl.sv
// ============================================================================
// Module      : regs_wb_ctrl
// Description : Register-file write-port arbiter (ALU vs load) with scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regs_wb_ctrl #(
    parameter int TAM        = regs_wb_ctrl_pkg::TAM,
    parameter int STARVE_MAX = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  alu_valid,
    input  logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] alu_addr,
    input  logic [TAM-1:0]                        alu_data,
    output logic                                  alu_ready,
    input  logic                                  mem_valid,
    input  logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] mem_addr,
    input  logic [TAM-1:0]                        mem_data,
    output logic                                  mem_ready,
    input  logic                                  iss_valid,
    input  logic                                  iss_is_load,
    input  logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] iss_dst,
    input  logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] iss_src1,
    input  logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] iss_src2,
    output logic                                  iss_hazard,
    output logic [regs_wb_ctrl_pkg::REG_ADDR_W-1:0] CORE_REG_RD,
    output logic [TAM-1:0]                        RD,
    output logic                                  write,
    output logic [regs_wb_ctrl_pkg::NREG-1:0]     busy
);

    import regs_wb_ctrl_pkg::*;

    localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

    src_e                  w_src;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [TAM-1:0]        w_data;
    logic                  w_wr;

    logic [STARVE_W-1:0]   starve_q;
    logic [STARVE_W-1:0]   starve_d;
    logic                  write_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [TAM-1:0]        data_q;

    // Loads win ties so the scoreboard drains, unless the ALU has waited too long.
    always_comb begin
        w_src = SRC_NONE;
        if (alu_valid && (!mem_valid || starve_q == c_starve_max)) begin
            w_src = SRC_ALU;
        end else if (mem_valid) begin
            w_src = SRC_MEM;
        end
    end

    assign alu_ready = (w_src == SRC_ALU);
    assign mem_ready = (w_src == SRC_MEM);
    assign w_addr    = (w_src == SRC_MEM) ? mem_addr : alu_addr;
    assign w_data    = (w_src == SRC_MEM) ? mem_data : alu_data;
    assign w_wr      = (w_src != SRC_NONE) && (w_addr != '0);

    always_comb begin
        starve_d = '0;
        if (alu_valid && w_src == SRC_MEM) begin
            starve_d = (starve_q == c_starve_max) ? starve_q : starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            write_q  <= w_wr;
            if (w_wr) begin
                addr_q <= w_addr;
                data_q <= w_data;
            end
        end
    end

    assign write       = write_q;
    assign CORE_REG_RD = addr_q;
    assign RD          = data_q;

    regs_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .chk_valid_i (iss_valid),
        .set_req_i   (iss_valid & iss_is_load),
        .dst_i       (iss_dst),
        .src1_i      (iss_src1),
        .src2_i      (iss_src2),
        .clr_en_i    (mem_valid & mem_ready),
        .clr_addr_i  (mem_addr),
        .busy_o      (busy),
        .hazard_o    (iss_hazard)
    );

endmodule

`default_nettype wire

// File: tb/tb_regs_wb_ctrl.sv
// ============================================================================
// Module      : tb_regs_wb_ctrl
// Description : Directed and random self-checking bench for regs_wb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regs_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        iss_valid;
    logic        iss_is_load;
    logic [3:0]  iss_dst;
    logic [3:0]  iss_src1;
    logic [3:0]  iss_src2;
    logic        iss_hazard;
    logic [3:0]  CORE_REG_RD;
    logic [15:0] RD;
    logic        write;
    logic [15:0] busy;

    int n_total;
    int n_bad;

    regs_wb_ctrl #(.TAM(16), .STARVE_MAX(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .iss_valid   (iss_valid),
        .iss_is_load (iss_is_load),
        .iss_dst     (iss_dst),
        .iss_src1    (iss_src1),
        .iss_src2    (iss_src2),
        .iss_hazard  (iss_hazard),
        .CORE_REG_RD (CORE_REG_RD),
        .RD          (RD),
        .write       (write),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file behind the write port, with RF1/RF2 read ports.
    logic        rf_clr;
    logic [15:0] rf [16];
    logic [15:0] rf1;
    logic [15:0] rf2;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (write && CORE_REG_RD != 4'd0) begin
            rf[CORE_REG_RD] <= RD;
        end
    end

    assign rf1 = rf[iss_src1];
    assign rf2 = rf[iss_src2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        iss_valid   = 1'b0;
        iss_is_load = 1'b0;
        iss_dst     = 4'd0;
        iss_src1    = 4'd0;
        iss_src2    = 4'd0;
    endtask

    logic [15:0] shadow [16];
    logic        p1_v, p2_v, alu_hs, mem_hs;
    logic [3:0]  p1_a, p2_a, prev1, prev2;
    logic [15:0] p1_d, p2_d;
    int          st;
    logic        exp_alu;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        rf_clr   = 1'b1;
        alu_addr = '0;
        alu_data = '0;
        mem_addr = '0;
        mem_data = '0;
        idle();
        #12;
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_addr", 32'(CORE_REG_RD), 32'd0);
        chk("rst_rd", 32'(RD), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'({alu_ready, mem_ready}), 32'd0);
        rst    = 1'b0;
        rf_clr = 1'b0;
        step();

        // Single ALU writeback
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
        #1;
        chk("alu_rdy", 32'(alu_ready), 32'd1);
        chk("alu_mem_rdy", 32'(mem_ready), 32'd0);
        step();
        idle();
        iss_src1 = 4'd3;
        chk("t1_write", 32'(write), 32'd1);
        chk("t1_addr", 32'(CORE_REG_RD), 32'd3);
        chk("t1_rd", 32'(RD), 32'h1234);
        step();
        chk("t1_wr_drop", 32'(write), 32'd0);
        chk("t1_rd_hold", 32'(RD), 32'h1234);
        chk("t1_rf1", 32'(rf1), 32'h1234);

        // Arbitration with STARVE_MAX=2: mem, mem, alu, mem
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'hA001;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'hB002;
        #1;
        chk("arb0_mem", 32'({alu_ready, mem_ready}), 32'b01);
        step();
        mem_addr = 4'd4; mem_data = 16'hB004;
        #1;
        chk("arb1_wr", 32'({write, CORE_REG_RD, RD}), {11'd0, 1'b1, 4'd2, 16'hB002});
        chk("arb1_mem", 32'({alu_ready, mem_ready}), 32'b01);
        step();
        mem_addr = 4'd6; mem_data = 16'hB006;
        #1;
        chk("arb2_wr", 32'({write, CORE_REG_RD, RD}), {11'd0, 1'b1, 4'd4, 16'hB004});
        chk("arb2_alu", 32'({alu_ready, mem_ready}), 32'b10);
        step();
        alu_addr = 4'd7; alu_data = 16'hA007;
        #1;
        chk("arb3_wr", 32'({write, CORE_REG_RD, RD}), {11'd0, 1'b1, 4'd1, 16'hA001});
        chk("arb3_mem", 32'({alu_ready, mem_ready}), 32'b01);
        step();
        idle();
        chk("arb4_wr", 32'({write, CORE_REG_RD, RD}), {11'd0, 1'b1, 4'd6, 16'hB006});
        step();
        chk("arb5_idle", 32'(write), 32'd0);

        // Scoreboard set, hazard, clear on load writeback
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 4'd5;
        #1;
        chk("sb_nohaz", 32'(iss_hazard), 32'd0);
        step();
        iss_is_load = 1'b0; iss_dst = 4'd1; iss_src1 = 4'd5;
        #1;
        chk("sb_busy5", 32'(busy), 32'h0020);
        chk("sb_haz", 32'(iss_hazard), 32'd1);
        step();
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'hC005;
        #1;
        chk("sb_haz_hs", 32'(iss_hazard), 32'd1);
        chk("sb_mem_rdy", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        #1;
        chk("sb_clr", 32'(busy), 32'd0);
        chk("sb_haz_off", 32'(iss_hazard), 32'd0);
        chk("sb_wr5", 32'({write, CORE_REG_RD}), 32'h15);
        iss_is_load = 1'b1; iss_dst = 4'd0; iss_src1 = 4'd0;
        step();
        idle();
        #1;
        chk("sb_dst0", 32'(busy), 32'd0);

        // Load writeback to r0
        mem_valid = 1'b1; mem_addr = 4'd0; mem_data = 16'hFFFF;
        #1;
        chk("r0_rdy", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        #1;
        chk("r0_nowr", 32'(write), 32'd0);
        chk("r0_hold", 32'({CORE_REG_RD, RD}), {12'd0, 4'd5, 16'hC005});

        // Reset mid-operation
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_dst = 4'd2;
        step();
        iss_dst = 4'd5;
        step();
        idle();
        alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 16'h9999;
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 16'h7777;
        #1;
        chk("mr_mem", 32'(mem_ready), 32'd1);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("mr_pre", 32'({write, busy}), {15'd0, 1'b1, 16'h0024});
        #1;
        rst = 1'b1;
        #1;
        chk("mr_write", 32'(write), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'h0101;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 16'h0202;
        #1;
        chk("mr_st0", 32'({alu_ready, mem_ready}), 32'b01);
        step();
        mem_addr = 4'd3;
        #1;
        chk("mr_st1", 32'({alu_ready, mem_ready}), 32'b01);
        step();
        mem_addr = 4'd4;
        #1;
        chk("mr_st2", 32'({alu_ready, mem_ready}), 32'b10);
        step();
        idle();
        step();
        step();

        // Random sweep against a shadow register file
        rf_clr = 1'b1;
        step();
        rf_clr = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        p1_v = 1'b0; p2_v = 1'b0; p1_a = '0; p2_a = '0; p1_d = '0; p2_d = '0;
        alu_hs = 1'b0; mem_hs = 1'b0; prev1 = 4'd0; prev2 = 4'd0; st = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            chk("sw_write", 32'(write), 32'(p1_v && p1_a != 4'd0));
            if (p1_v && p1_a != 4'd0) begin
                chk("sw_wdata", 32'({CORE_REG_RD, RD}), {12'd0, p1_a, p1_d});
            end
            if (p2_v) shadow[p2_a] = p2_d;
            p2_v = p1_v && p1_a != 4'd0;
            p2_a = p1_a;
            p2_d = p1_d;
            if (!alu_valid || alu_hs) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_addr  = 4'($urandom_range(0, 15));
                alu_data  = 16'($urandom);
            end
            if (!mem_valid || mem_hs) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_addr  = 4'($urandom_range(0, 15));
                mem_data  = 16'($urandom);
            end
            iss_src1 = 4'($urandom_range(0, 15));
            iss_src2 = 4'($urandom_range(0, 15));
            #1;
            if (iss_src1 != prev1) chk("sw_rf1", 32'(rf1), 32'(shadow[iss_src1]));
            if (iss_src2 != prev2) chk("sw_rf2", 32'(rf2), 32'(shadow[iss_src2]));
            prev1 = iss_src1;
            prev2 = iss_src2;
            exp_alu = alu_valid && (!mem_valid || st == 2);
            chk("sw_grant", 32'({alu_ready, mem_ready}), 32'({exp_alu, mem_valid && !exp_alu}));
            st = (alu_valid && mem_valid && !exp_alu) ? ((st == 2) ? 2 : st + 1) : 0;
            alu_hs = alu_valid && alu_ready;
            mem_hs = mem_valid && mem_ready;
            p1_v = alu_hs || mem_hs;
            p1_a = mem_hs ? mem_addr : alu_addr;
            p1_d = mem_hs ? mem_data : alu_data;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
